// File: rtl/ir_nec_pkg.sv
// Shared state encoding and NEC time-unit counts for the IR transmitter.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } state_t;

    localparam int LEAD_MARK_UNITS  = 16;
    localparam int LEAD_SPACE_UNITS = 8;
    localparam int REP_SPACE_UNITS  = 4;
    localparam int BIT_MARK_UNITS   = 1;
    localparam int ZERO_SPACE_UNITS = 1;
    localparam int ONE_SPACE_UNITS  = 3;
    localparam int STOP_UNITS       = 1;

    function automatic logic is_mark(input state_t s);
        return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
    endfunction

endpackage

// File: rtl/ir_nec_transmitter_carrier.sv
// Free-running ~38 kHz carrier; restart re-phases it so a burst begins high.
module ir_carrier_gen #(
    parameter int CARRIER_DIV  = 1316,
    parameter int CARRIER_HIGH = 438
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic carrier
);

    localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CARRIER_DIV - 1);
    localparam logic [CW-1:0] CNT_HIGH = CW'(CARRIER_HIGH);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt + 1'b1;
        if (restart || (cnt == CNT_LAST)) begin
            cnt_next = '0;
        end
    end

    // carrier reflects the phase held after the coming edge, so a register
    // fed from it in the parent lines up with the counter it shadows.
    assign carrier = (cnt_next < CNT_HIGH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/ir_nec_transmitter.sv
// NEC IR transmitter: full frame (leader, 32 bits LSB-first, stop) or repeat
// code, with registered envelope and carrier-modulated LED drive.
module ir_nec_transmitter
    import ir_nec_pkg::*;
#(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_DIV  = 1316,
    parameter int CARRIER_HIGH = 438,
    parameter int GAP_UNITS    = 72
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        repeat_req,
    input  logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic        envelope,
    output logic        ir_tx
);

    localparam int MAX_UNITS = (GAP_UNITS > LEAD_MARK_UNITS) ? GAP_UNITS : LEAD_MARK_UNITS;
    localparam int UW = $clog2(MAX_UNITS + 1);
    localparam int CW = $clog2(UNIT_CYCLES + 1);
    localparam logic [CW-1:0] CYC_LAST   = CW'(UNIT_CYCLES - 1);
    // done is raised one cycle early so it is high in the final GAP cycle;
    // this assumes UNIT_CYCLES >= 2.
    localparam logic [CW-1:0] CYC_PENULT = CW'(UNIT_CYCLES - 2);
    localparam logic [UW-1:0] GAP_LAST   = UW'(GAP_UNITS - 1);

    state_t        state;
    logic [CW-1:0] cyc;
    logic [UW-1:0] unit;
    logic [4:0]    bit_idx;
    logic          last_bit;
    logic          is_repeat;
    logic [31:0]   shreg;

    logic [UW-1:0] cur_units;
    logic          accept;
    logic          unit_end;
    logic          enter_mark;
    logic          leave_mark;
    logic          env_next;
    logic          carrier;

    always_comb begin
        cur_units = UW'(1);
        case (state)
            LEAD_MARK:  cur_units = UW'(LEAD_MARK_UNITS);
            LEAD_SPACE: cur_units = is_repeat ? UW'(REP_SPACE_UNITS) : UW'(LEAD_SPACE_UNITS);
            BIT_MARK:   cur_units = UW'(BIT_MARK_UNITS);
            BIT_SPACE:  cur_units = shreg[0] ? UW'(ONE_SPACE_UNITS) : UW'(ZERO_SPACE_UNITS);
            STOP_MARK:  cur_units = UW'(STOP_UNITS);
            GAP:        cur_units = UW'(GAP_UNITS);
            default:    cur_units = UW'(1);
        endcase
    end

    assign accept     = (state == IDLE) && (start || repeat_req);
    assign unit_end   = (state != IDLE) && (cyc == CYC_LAST) && (unit == cur_units - 1'b1);
    // Every space ends in a mark, so any space expiry is a mark entry.
    assign enter_mark = accept || (unit_end && ((state == LEAD_SPACE) || (state == BIT_SPACE)));
    assign leave_mark = unit_end && is_mark(state);
    assign env_next   = enter_mark || (envelope && !leave_mark);

    ir_carrier_gen #(
        .CARRIER_DIV (CARRIER_DIV),
        .CARRIER_HIGH(CARRIER_HIGH)
    ) u_carrier (
        .clk    (clk),
        .rst    (rst),
        .restart(enter_mark),
        .carrier(carrier)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cyc       <= '0;
            unit      <= '0;
            bit_idx   <= '0;
            last_bit  <= 1'b0;
            is_repeat <= 1'b0;
            shreg     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            envelope  <= 1'b0;
            ir_tx     <= 1'b0;
        end else begin
            done     <= 1'b0;
            envelope <= env_next;
            ir_tx    <= env_next && carrier;

            if (state != IDLE) begin
                if (unit_end) begin
                    cyc  <= '0;
                    unit <= '0;
                end else if (cyc == CYC_LAST) begin
                    cyc  <= '0;
                    unit <= unit + 1'b1;
                end else begin
                    cyc <= cyc + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= LEAD_MARK;
                        busy      <= 1'b1;
                        is_repeat <= !start;
                        shreg     <= data;
                        bit_idx   <= '0;
                        last_bit  <= 1'b0;
                        cyc       <= '0;
                        unit      <= '0;
                    end
                end
                LEAD_MARK: begin
                    if (unit_end) state <= LEAD_SPACE;
                end
                LEAD_SPACE: begin
                    if (unit_end) state <= is_repeat ? STOP_MARK : BIT_MARK;
                end
                BIT_MARK: begin
                    if (unit_end) state <= BIT_SPACE;
                end
                BIT_SPACE: begin
                    if (unit_end) begin
                        shreg <= shreg >> 1;
                        if (last_bit) begin
                            state <= STOP_MARK;
                        end else begin
                            state    <= BIT_MARK;
                            bit_idx  <= bit_idx + 1'b1;
                            last_bit <= (bit_idx == 5'd30);
                        end
                    end
                end
                STOP_MARK: begin
                    if (unit_end) state <= GAP;
                end
                GAP: begin
                    if ((unit == GAP_LAST) && (cyc == CYC_PENULT)) done <= 1'b1;
                    if (unit_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// Bench for ir_nec_transmitter: a segment-level waveform model feeds an
// expected queue that is compared against the outputs every cycle.
module tb_ir_nec_transmitter;

    localparam int UC = 10;
    localparam int CD = 4;
    localparam int CH = 2;
    localparam int GU = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        repeat_req;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic        envelope;
    logic        ir_tx;

    always #5 clk = ~clk;

    ir_nec_transmitter #(
        .UNIT_CYCLES (UC),
        .CARRIER_DIV (CD),
        .CARRIER_HIGH(CH),
        .GAP_UNITS   (GU)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .repeat_req(repeat_req),
        .data      (data),
        .busy      (busy),
        .done      (done),
        .envelope  (envelope),
        .ir_tx     (ir_tx)
    );

    int total = 0;
    int bad   = 0;

    // Each entry is {busy, done, envelope, ir_tx} for one cycle.
    logic [3:0] exp_q[$];

    int run      = 0;
    int last_run = 0;
    int runs     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Waveform model: list the NEC segments in units, then expand to cycles.
    task automatic push_frame(input logic [31:0] d, input bit rep, output int n);
        int  lens[$];
        bit  marks[$];
        logic [3:0] e;
        lens.push_back(16); marks.push_back(1'b1);
        lens.push_back(rep ? 4 : 8); marks.push_back(1'b0);
        if (!rep) begin
            for (int i = 0; i < 32; i++) begin
                lens.push_back(1); marks.push_back(1'b1);
                lens.push_back(d[i] ? 3 : 1); marks.push_back(1'b0);
            end
        end
        lens.push_back(1); marks.push_back(1'b1);
        lens.push_back(GU); marks.push_back(1'b0);
        n = 0;
        for (int s = 0; s < lens.size(); s++) begin
            for (int k = 0; k < lens[s] * UC; k++) begin
                exp_q.push_back({1'b1, 1'b0, marks[s], marks[s] && ((k % CD) < CH)});
                n++;
            end
        end
        e = exp_q.pop_back();
        e[2] = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic r, output int n);
        @(negedge clk);
        data = d;
        start = s;
        repeat_req = r;
        @(posedge clk);
        #1;
        push_frame(d, !s, n);
        @(negedge clk);
        start = 1'b0;
        repeat_req = 1'b0;
        data = ~d;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 5000) begin
            @(posedge clk);
            k++;
        end
        check("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    initial begin : compare
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #2;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
            check("wave", 32'({busy, done, envelope, ir_tx}), 32'(e));
        end
    end

    initial begin : busy_monitor
        forever begin
            @(posedge clk);
            #2;
            if (busy === 1'b1) begin
                run++;
            end else if (run > 0) begin
                last_run = run;
                runs++;
                run = 0;
            end
        end
    end

    initial begin : main
        int n;
        int w;
        int runs0;
        logic [31:0] d;
        rst = 1'b1;
        start = 1'b0;
        repeat_req = 1'b0;
        data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);

        // Full frame, 16 ones: 121 units + 4 gap units.
        send(32'h00FF_00FF, 1'b1, 1'b0, n);
        check("model_len_ff", n, 1250);
        drain();
        check("busy_len_ff", last_run, 1250);

        // Repeat code: 16 + 4 + 1 + 4 units.
        send(32'h0, 1'b0, 1'b1, n);
        check("model_len_rep", n, 250);
        drain();
        check("busy_len_rep", last_run, 250);

        // start and repeat_req together: full frame of zero bits.
        send(32'h0, 1'b1, 1'b1, n);
        check("model_len_zero", n, 930);
        drain();
        check("busy_len_zero", last_run, 930);

        // Requests mid-frame must leave the waveform untouched.
        send(32'h1234_5678, 1'b1, 1'b0, n);
        check("model_len_1234", n, 1190);
        repeat (500) @(negedge clk);
        data = 32'hFFFF_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        repeat_req = 1'b1;
        @(negedge clk);
        repeat_req = 1'b0;
        drain();
        check("busy_len_midreq", last_run, 1190);

        // repeat_req held high: second code accepted right after the idle cycle.
        runs0 = runs;
        @(negedge clk);
        repeat_req = 1'b1;
        @(posedge clk);
        #1;
        push_frame(32'h0, 1'b1, n);
        exp_q.push_back(4'b0000);
        push_frame(32'h0, 1'b1, n);
        repeat (300) @(negedge clk);
        repeat_req = 1'b0;
        drain();
        check("b2b_runs", runs - runs0, 2);
        check("b2b_len", last_run, 250);

        // Reset three cycles into the BIT_SPACE of bit 12.
        d = 32'hA5A5_1234;
        send(d, 1'b1, 1'b0, n);
        w = 240;
        for (int i = 0; i < 12; i++) w += 10 + (d[i] ? 30 : 10);
        w += 10 + 3;
        repeat (w) @(negedge clk);
        check("pre_rst_model_env", 32'(exp_q[0][1]), 0);
        rst = 1'b1;
        #1;
        check("rst_envelope", 32'(envelope), 0);
        check("rst_ir_tx", 32'(ir_tx), 0);
        check("rst_busy", 32'(busy), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send(d, 1'b1, 1'b0, n);
        check("model_len_a5", n, 1190);
        drain();
        check("busy_len_after_rst", last_run, 1190);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
